sram_1mx8: RTL and testbench
============================

// Module: sram_1mx8
// PURPOSE
//  Wishbone-classic slave bridging an on-chip mentor to an external 1Mx8 async SRAM.
//  One single-beat read or write per strobe; fixed-cycle SRAM timing on chip pins.
//  Sits between the system bus and the top-level pins (o_addr/io_c_data/o_n_oe/o_n_we).
// PARAMETERS
//  ADDR_WIDTH  20  SRAM/bus address width (1M locations)
//  DATA_WIDTH  8   SRAM/bus data width
//  DTAG_WIDTH  2   TGD_I width (accepted, ignored)
//  ATAG_WIDTH  2   TGA_I width (accepted, ignored)
//  CTAG_WIDTH  2   TGC_I width (accepted, ignored)
// PORTS
//  CLK_I      in   1           system clock, all logic on rising edge
//  RST_I      in   1           synchronous, active-low reset
//  WE_I       in   1           1=write, 0=read; sampled at accept
//  ADR_I      in   ADDR_WIDTH  word address; sampled at accept
//  TGA_I      in   ATAG_WIDTH  address tag, ignored
//  DAT_I      in   DATA_WIDTH  write data; sampled at accept
//  TGD_I      in   DTAG_WIDTH  data tag, ignored
//  LOCK_I     in   1           ignored
//  SEL_I      in   1           ignored (single byte lane)
//  CYC_I      in   1           ignored; STB_I alone starts a transfer
//  TGC_I      in   CTAG_WIDTH  cycle tag, ignored
//  STB_I      in   1           transfer request
//  DAT_O      out  DATA_WIDTH  last read data (registered)
//  ACK_O      out  1           one-cycle transfer-complete pulse
//  ERR_O      out  1           constant 0
//  RTY_O      out  1           constant 0
//  o_addr     out  ADDR_WIDTH  SRAM address pins (registered)
//  io_c_data  inout DATA_WIDTH SRAM data pins; driven only in write states, else Z
//  o_n_oe     out  1           SRAM output enable, active low
//  o_n_we     out  1           SRAM write enable, active low
// BEHAVIOUR
//  Reset (RST_I=0 at edge): state IDLE, o_n_oe=1, o_n_we=1, io_c_data=Z, ACK_O=0,
//   DAT_O=0, o_addr=0. Applies mid-transfer too: pins released that same edge, no ACK.
//  States: IDLE, W_SETUP, W_PULSE1, W_PULSE2, W_HOLD, R_OE, R_WAIT, ACK, WAIT_RELEASE.
//  E0 = edge where state=IDLE and STB_I=1 (accept): latch ADR_I->o_addr, DAT_I, WE_I.
//  Write: E0->W_SETUP (bus driven, n_we=1); E1->W_PULSE1 n_we=0; E2->W_PULSE2;
//   E3->W_HOLD n_we=1, data still driven; E4->ACK: bus Z, ACK_O=1. Latency 4 edges.
//  Read: E0->R_OE n_oe=0; E1->R_WAIT; E2: DAT_O<=io_c_data, n_oe=1, ACK_O=1 (->ACK).
//  ACK: next edge ACK_O=0; go IDLE if STB_I=0 else WAIT_RELEASE.
//  WAIT_RELEASE: stay until STB_I=0, then IDLE. A held strobe never retriggers;
//   a new transfer needs STB_I low for >=1 edge then high again.
//  o_n_oe and o_n_we never low simultaneously; io_c_data never driven while n_oe=0.
//  STB_I dropping mid-transfer does not abort; transfer completes and ACKs.
//  DAT_O holds value until next read completes; writes do not change it.
//  Tag, SEL, LOCK, CYC inputs have no effect; ERR_O/RTY_O tied 0.
// TESTING
//  Reset: RST_I=0 4 cycles -> n_oe=1, n_we=1, io_c_data=Z, ACK_O=0, DAT_O=0.
//  Write 8'hC9 @ 1777 (20'h006F1), STB_I held 7 cycles -> o_addr=006F1, io=C9,
//   n_we low exactly 2 cycles, one ACK pulse at E4, no second write.
//  Read 20'h006F1 with SRAM model returning 8'h5A -> n_oe low 2 cycles, DAT_O=5A, ACK at E2.
//  Reset asserted during W_PULSE1 -> n_we=1 and bus Z at that edge, no ACK; next STB works.
//  Back-to-back: STB dropped after ACK, raised next cycle -> second transfer accepted at once.
//  CYC_I=0, tags/SEL/LOCK random -> behaviour identical; ERR_O=RTY_O=0 throughout.

Source files
------------

// File: rtl/sram_1mx8.sv
// Wishbone-classic slave driving an external 1Mx8 asynchronous SRAM with
// fixed-cycle read and write timing on the chip pins.
module sram_1mx8 #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DTAG_WIDTH = 2,
  parameter int unsigned ATAG_WIDTH = 2,
  parameter int unsigned CTAG_WIDTH = 2
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  WE_I,
  input  logic [ADDR_WIDTH-1:0] ADR_I,
  input  logic [ATAG_WIDTH-1:0] TGA_I,
  input  logic [DATA_WIDTH-1:0] DAT_I,
  input  logic [DTAG_WIDTH-1:0] TGD_I,
  input  logic                  LOCK_I,
  input  logic                  SEL_I,
  input  logic                  CYC_I,
  input  logic [CTAG_WIDTH-1:0] TGC_I,
  input  logic                  STB_I,
  output logic [DATA_WIDTH-1:0] DAT_O,
  output logic                  ACK_O,
  output logic                  ERR_O,
  output logic                  RTY_O,
  output logic [ADDR_WIDTH-1:0] o_addr,
  inout  wire  [DATA_WIDTH-1:0] io_c_data,
  output logic                  o_n_oe,
  output logic                  o_n_we
);

  localparam logic [3:0] IDLE         = 4'd0;
  localparam logic [3:0] W_SETUP      = 4'd1;
  localparam logic [3:0] W_PULSE1     = 4'd2;
  localparam logic [3:0] W_PULSE2     = 4'd3;
  localparam logic [3:0] W_HOLD       = 4'd4;
  localparam logic [3:0] R_OE         = 4'd5;
  localparam logic [3:0] R_WAIT       = 4'd6;
  localparam logic [3:0] ACK          = 4'd7;
  localparam logic [3:0] WAIT_RELEASE = 4'd8;

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  n_oe_q, n_oe_d;
  logic                  n_we_q, n_we_d;
  logic                  drive_q, drive_d;

  // Tags, lane select, lock and cycle qualifiers carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{TGA_I, TGD_I, LOCK_I, SEL_I, CYC_I, TGC_I};

  // Next-state and next-pin values; pins default to the idle (released) level.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    n_oe_d  = 1'b1;
    n_we_d  = 1'b1;
    drive_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (STB_I) begin
          addr_d  = ADR_I;
          wdata_d = DAT_I;
          if (WE_I) begin
            state_d = W_SETUP;
            drive_d = 1'b1;
          end else begin
            state_d = R_OE;
            n_oe_d  = 1'b0;
          end
        end
      end
      W_SETUP: begin
        state_d = W_PULSE1;
        drive_d = 1'b1;
        n_we_d  = 1'b0;
      end
      W_PULSE1: begin
        state_d = W_PULSE2;
        drive_d = 1'b1;
        n_we_d  = 1'b0;
      end
      W_PULSE2: begin
        // Write strobe rises while data is still held on the bus.
        state_d = W_HOLD;
        drive_d = 1'b1;
      end
      W_HOLD: begin
        state_d = ACK;
        ack_d   = 1'b1;
      end
      R_OE: begin
        state_d = R_WAIT;
        n_oe_d  = 1'b0;
      end
      R_WAIT: begin
        state_d = ACK;
        rdata_d = io_c_data;
        ack_d   = 1'b1;
      end
      ACK: begin
        state_d = STB_I ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: begin
        // A strobe held past its acknowledge must not start another transfer.
        if (!STB_I) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pin registers with synchronous active-low reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      n_oe_q  <= 1'b1;
      n_we_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      n_oe_q  <= n_oe_d;
      n_we_q  <= n_we_d;
      drive_q <= drive_d;
    end
  end

  assign io_c_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign DAT_O     = rdata_q;
  assign ACK_O     = ack_q;
  assign ERR_O     = 1'b0;
  assign RTY_O     = 1'b0;
  assign o_addr    = addr_q;
  assign o_n_oe    = n_oe_q;
  assign o_n_we    = n_we_q;

endmodule

// File: tb/tb_sram_1mx8.sv
// Self-checking bench for sram_1mx8: directed vector table, reset corner
// cases, then randomized transfers against an abstract memory model.
module tb_sram_1mx8;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic          WE_I;
  logic [AW-1:0] ADR_I;
  logic [1:0]    TGA_I;
  logic [DW-1:0] DAT_I;
  logic [1:0]    TGD_I;
  logic          LOCK_I;
  logic          SEL_I;
  logic          CYC_I;
  logic [1:0]    TGC_I;
  logic          STB_I;
  logic [DW-1:0] DAT_O;
  logic          ACK_O;
  logic          ERR_O;
  logic          RTY_O;
  logic [AW-1:0] o_addr;
  tri0  [DW-1:0] io_c_data;
  logic          o_n_oe;
  logic          o_n_we;

  int total = 0;
  int passed = 0;

  // External SRAM chip model: unwritten locations hold an address-derived pattern.
  logic [DW-1:0] smem [int];
  logic [DW-1:0] sram_q = '0;
  logic          pre_go = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;

  // Abstract reference: what each address should contain after completed writes.
  logic [DW-1:0] ref_mem [int];

  sram_1mx8 dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .WE_I(WE_I), .ADR_I(ADR_I), .TGA_I(TGA_I),
    .DAT_I(DAT_I), .TGD_I(TGD_I), .LOCK_I(LOCK_I), .SEL_I(SEL_I), .CYC_I(CYC_I),
    .TGC_I(TGC_I), .STB_I(STB_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .ERR_O(ERR_O),
    .RTY_O(RTY_O), .o_addr(o_addr), .io_c_data(io_c_data), .o_n_oe(o_n_oe),
    .o_n_we(o_n_we)
  );

  always #5 CLK_I = ~CLK_I;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return 8'(a) ^ 8'h3C;
  endfunction

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (smem.exists(int'(a))) return smem[int'(a)];
    return dflt(a);
  endfunction

  // Chip drives the bus while output-enabled and not being written.
  assign io_c_data = (!o_n_oe && o_n_we) ? sram_q : 8'bzzzzzzzz;

  always @(negedge CLK_I) sram_q <= rd(o_addr);

  // Chip latches data on the rising edge of the write strobe; pre_go preloads.
  always @(posedge o_n_we or posedge pre_go) begin
    if (pre_go) smem[int'(pre_a)] = pre_d;
    else        smem[int'(o_addr)] = io_c_data;
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_go = 1'b1;
    #1;
    pre_go = 1'b0;
  endtask

  // One transfer: returns edges from accept to ACK, strobe-low sample count,
  // the address/data seen on the pins, and a flag for any protocol violation.
  task automatic run_xfer(input bit we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input int hold, input bit drop,
                          output int lat, output int low,
                          output logic [AW-1:0] a_seen, output logic [DW-1:0] d_seen,
                          output bit bad);
    WE_I   = we;
    ADR_I  = adr;
    DAT_I  = dat;
    STB_I  = 1'b1;
    CYC_I  = 1'($urandom);
    TGA_I  = 2'($urandom);
    TGD_I  = 2'($urandom);
    TGC_I  = 2'($urandom);
    SEL_I  = 1'($urandom);
    LOCK_I = 1'($urandom);
    lat = -1; low = 0; bad = 1'b0; a_seen = '0; d_seen = '0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (n == 0 && drop) STB_I = 1'b0;
      if (!o_n_oe && !o_n_we) bad = 1'b1;
      if (!o_n_oe && io_c_data !== sram_q) bad = 1'b1;
      if (ERR_O || RTY_O) bad = 1'b1;
      if (!o_n_we) begin
        if (we) low++; else bad = 1'b1;
        a_seen = o_addr;
        d_seen = io_c_data;
      end
      if (!o_n_oe) begin
        if (!we) low++; else bad = 1'b1;
        a_seen = o_addr;
      end
      if (ACK_O) begin
        lat = n;
        break;
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      if (ACK_O || !o_n_we || !o_n_oe) bad = 1'b1;
    end
    STB_I = 1'b0;
    tick();
    if (ACK_O || !o_n_we || !o_n_oe) bad = 1'b1;
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    bit            pre;
    logic [DW-1:0] pre_val;
    int            hold;
    int            exp_lat;
    int            exp_low;
    logic [DW-1:0] exp_dat_o;
  } vec_t;

  initial begin
    vec_t          vecs [8];
    int            lat, low;
    logic [AW-1:0] a_seen;
    logic [DW-1:0] d_seen;
    bit            bad, bad_acc;
    logic [DW-1:0] dato_exp;

    vecs[0] = '{we:1'b1, adr:20'h006F1, dat:8'hC9, pre:1'b0, pre_val:8'h00, hold:2, exp_lat:4, exp_low:2, exp_dat_o:8'h00};
    vecs[1] = '{we:1'b0, adr:20'h006F1, dat:8'h00, pre:1'b0, pre_val:8'h00, hold:0, exp_lat:2, exp_low:2, exp_dat_o:8'hC9};
    vecs[2] = '{we:1'b0, adr:20'h006F1, dat:8'h00, pre:1'b1, pre_val:8'h5A, hold:0, exp_lat:2, exp_low:2, exp_dat_o:8'h5A};
    vecs[3] = '{we:1'b1, adr:20'h00002, dat:8'h3C, pre:1'b0, pre_val:8'h00, hold:0, exp_lat:4, exp_low:2, exp_dat_o:8'h5A};
    vecs[4] = '{we:1'b0, adr:20'h00002, dat:8'h00, pre:1'b0, pre_val:8'h00, hold:1, exp_lat:2, exp_low:2, exp_dat_o:8'h3C};
    vecs[5] = '{we:1'b0, adr:20'hFFFFF, dat:8'h00, pre:1'b1, pre_val:8'hA7, hold:0, exp_lat:2, exp_low:2, exp_dat_o:8'hA7};
    vecs[6] = '{we:1'b1, adr:20'hFFFFF, dat:8'h81, pre:1'b0, pre_val:8'h00, hold:3, exp_lat:4, exp_low:2, exp_dat_o:8'hA7};
    vecs[7] = '{we:1'b0, adr:20'hFFFFF, dat:8'h00, pre:1'b0, pre_val:8'h00, hold:0, exp_lat:2, exp_low:2, exp_dat_o:8'h81};

    RST_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
    TGA_I = '0; TGD_I = '0; TGC_I = '0; LOCK_I = 1'b0; SEL_I = 1'b0; CYC_I = 1'b0;

    // Reset values.
    repeat (4) tick();
    chk("rst_n_oe", 32'(o_n_oe), 32'd1);
    chk("rst_n_we", 32'(o_n_we), 32'd1);
    chk("rst_io", 32'(io_c_data), 32'd0);
    chk("rst_ack", 32'(ACK_O), 32'd0);
    chk("rst_dat_o", 32'(DAT_O), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_err_rty", 32'({ERR_O, RTY_O}), 32'd0);
    RST_I = 1'b1;
    tick();

    // Directed vector table; zero-hold entries also exercise back-to-back accept.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre) preload(vecs[i].adr, vecs[i].pre_val);
      run_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].hold, 1'b0,
               lat, low, a_seen, d_seen, bad);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_strobe_low", i), 32'(low), 32'(vecs[i].exp_low));
      chk($sformatf("v%0d_addr", i), 32'(a_seen), 32'(vecs[i].adr));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_bus_data", i), 32'(d_seen), 32'(vecs[i].dat));
        chk($sformatf("v%0d_sram", i), 32'(rd(vecs[i].adr)), 32'(vecs[i].dat));
      end
      chk($sformatf("v%0d_dat_o", i), 32'(DAT_O), 32'(vecs[i].exp_dat_o));
      chk($sformatf("v%0d_protocol", i), 32'(bad), 32'd0);
    end
    dato_exp = 8'h81;

    // Reset landing in the first write-pulse cycle.
    WE_I = 1'b1; ADR_I = 20'h55555; DAT_I = 8'hE7; STB_I = 1'b1;
    tick();
    STB_I = 1'b0;
    tick();
    chk("midrst_pulse_n_we", 32'(o_n_we), 32'd0);
    RST_I = 1'b0;
    tick();
    chk("midrst_n_we", 32'(o_n_we), 32'd1);
    chk("midrst_io", 32'(io_c_data), 32'd0);
    chk("midrst_ack", 32'(ACK_O), 32'd0);
    chk("midrst_n_oe", 32'(o_n_oe), 32'd1);
    chk("midrst_dat_o", 32'(DAT_O), 32'd0);
    RST_I = 1'b1;
    bad_acc = 1'b0;
    repeat (6) begin
      tick();
      if (ACK_O || !o_n_we || !o_n_oe) bad_acc = 1'b1;
    end
    chk("midrst_quiet", 32'(bad_acc), 32'd0);
    run_xfer(1'b0, 20'h006F1, 8'h00, 0, 1'b0, lat, low, a_seen, d_seen, bad);
    chk("postrst_latency", 32'(lat), 32'd2);
    chk("postrst_dat_o", 32'(DAT_O), 32'h5A);
    chk("postrst_protocol", 32'(bad), 32'd0);
    dato_exp = 8'h5A;

    // Randomized transfers, ignored inputs randomized, against the reference model.
    for (int i = 0; i < 80; i++) begin
      bit            we;
      bit            drop;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            hold;
      we   = 1'($urandom);
      a    = 20'h00100 + 20'($urandom_range(0, 15));
      d    = 8'($urandom_range(1, 255));
      hold = $urandom_range(0, 2);
      drop = ($urandom_range(0, 3) == 0);
      run_xfer(we, a, d, hold, drop, lat, low, a_seen, d_seen, bad);
      if (we) begin
        ref_mem[int'(a)] = d;
      end else begin
        dato_exp = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
      end
      chk($sformatf("r%0d_latency", i), 32'(lat), we ? 32'd4 : 32'd2);
      chk($sformatf("r%0d_dat_o", i), 32'(DAT_O), 32'(dato_exp));
      chk($sformatf("r%0d_protocol", i), 32'(bad), 32'd0);
      if (we) chk($sformatf("r%0d_sram", i), 32'(rd(a)), 32'(d));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
